// File: rtl/led_anim_gen.sv
// LED animation generator: prescaled step strobe driving chase, fill/drain, bounce and breathe patterns.
// Optional breathe (PWM) mode is built only when LED_ANIM_BREATHE_EN is defined; otherwise mode 3 stays dark.
module led_anim_gen #(
    parameter int N     = 8,
    parameter int DIV_W = 16,
    parameter int PWM_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] step_load,
    input  logic [PWM_W-1:0] brightness,
    output logic [N-1:0]     led_out,
    output logic             step_pulse
);

    localparam int POS_W = $clog2(N + 1);
    localparam logic [POS_W-1:0] POS_ZERO = POS_W'(0);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(N - 1);
    localparam logic [POS_W-1:0] POS_FULL = POS_W'(N);
    localparam logic [N-1:0]     LED_NONE = {N{1'b0}};
    localparam logic [N-1:0]     LED_ALL  = {N{1'b1}};
    localparam logic [N-1:0]     LED_LSB  = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

    logic [DIV_W-1:0] prescaler_r, prescaler_s;
    logic [1:0]       mode_r, mode_s;
    logic [POS_W-1:0] pos_r, pos_s;
    dir_t             dir_r, dir_s;
    logic [POS_W-1:0] fill_r, fill_s, fill_next_s;
    logic             fill_dn_r, fill_dn_s;
    logic [N-1:0]     led_r, led_s;
    logic             pulse_r, pulse_s;
    logic             hit_s;

`ifdef LED_ANIM_BREATHE_EN
    logic [PWM_W-1:0] duty_r, duty_s;
    logic             duty_dn_r, duty_dn_s;
    logic [PWM_W-1:0] pwm_cnt_r, pwm_cnt_s;
`else
    logic             brightness_unused_s;
    assign brightness_unused_s = ^brightness;
`endif

    assign led_out    = led_r;
    assign step_pulse = pulse_r;

    // Next-state computation for prescaler, pattern state and LED drive.
    always_comb begin
        prescaler_s = prescaler_r;
        mode_s      = mode_r;
        pos_s       = pos_r;
        dir_s       = dir_r;
        fill_s      = fill_r;
        fill_dn_s   = fill_dn_r;
        fill_next_s = fill_r;
        led_s       = led_r;
        pulse_s     = 1'b0;
`ifdef LED_ANIM_BREATHE_EN
        duty_s      = duty_r;
        duty_dn_s   = duty_dn_r;
        pwm_cnt_s   = pwm_cnt_r;
`endif
        // >= rather than == so a shrinking step_load ends the step at once.
        hit_s = (prescaler_r >= step_load);

        if (mode != mode_r) begin
            mode_s      = mode;
            prescaler_s = {DIV_W{1'b0}};
            pos_s       = POS_TOP;
            dir_s       = DIR_DOWN;
            fill_s      = POS_ZERO;
            fill_dn_s   = 1'b0;
            led_s       = LED_NONE;
            pulse_s     = 1'b0;
`ifdef LED_ANIM_BREATHE_EN
            duty_s      = {PWM_W{1'b0}};
            duty_dn_s   = 1'b0;
            pwm_cnt_s   = {PWM_W{1'b0}};
`endif
        end else begin
            if (hit_s) begin
                prescaler_s = {DIV_W{1'b0}};
                pulse_s     = 1'b1;
                case (mode_r)
                    2'd0: begin
                        led_s = LED_LSB << pos_r;
                        if (pos_r == POS_ZERO) begin
                            pos_s = POS_TOP;
                        end else begin
                            pos_s = pos_r - POS_ONE;
                        end
                    end
                    2'd1: begin
                        if (fill_dn_r == 1'b0) begin
                            fill_next_s = fill_r + POS_ONE;
                            fill_dn_s   = (fill_next_s == POS_FULL);
                        end else begin
                            fill_next_s = fill_r - POS_ONE;
                            fill_dn_s   = (fill_next_s != POS_ZERO);
                        end
                        fill_s = fill_next_s;
                        led_s  = ~(LED_ALL >> fill_next_s);
                    end
                    2'd2: begin
                        led_s = LED_LSB << pos_r;
                        if (dir_r == DIR_DOWN) begin
                            if (pos_r == POS_ZERO) begin
                                dir_s = DIR_UP;
                                pos_s = POS_ONE;
                            end else begin
                                pos_s = pos_r - POS_ONE;
                            end
                        end else begin
                            if (pos_r == POS_TOP) begin
                                dir_s = DIR_DOWN;
                                pos_s = POS_TOP - POS_ONE;
                            end else begin
                                pos_s = pos_r + POS_ONE;
                            end
                        end
                    end
                    2'd3: begin
`ifdef LED_ANIM_BREATHE_EN
                        if (duty_dn_r == 1'b0) begin
                            if (duty_r < brightness) begin
                                duty_s = duty_r + PWM_W'(1);
                            end else begin
                                duty_dn_s = 1'b1;
                                duty_s    = (duty_r != {PWM_W{1'b0}}) ? duty_r - PWM_W'(1) : {PWM_W{1'b0}};
                            end
                        end else begin
                            if (duty_r == {PWM_W{1'b0}}) begin
                                duty_dn_s = 1'b0;
                                duty_s    = (brightness != {PWM_W{1'b0}}) ? PWM_W'(1) : {PWM_W{1'b0}};
                            end else begin
                                duty_s = duty_r - PWM_W'(1);
                            end
                        end
`else
                        led_s = LED_NONE;
`endif
                    end
                    default: begin
                        led_s = LED_NONE;
                    end
                endcase
            end else begin
                prescaler_s = prescaler_r + DIV_W'(1);
            end
`ifdef LED_ANIM_BREATHE_EN
            // PWM output refreshes every cycle, not only on steps.
            pwm_cnt_s = pwm_cnt_r + PWM_W'(1);
            if (mode_r == 2'd3) begin
                led_s = (pwm_cnt_r < duty_r) ? LED_ALL : LED_NONE;
            end else begin
                led_s = led_s;
            end
`endif
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_r <= {DIV_W{1'b0}};
            mode_r      <= 2'd0;
            pos_r       <= POS_TOP;
            dir_r       <= DIR_DOWN;
            fill_r      <= POS_ZERO;
            fill_dn_r   <= 1'b0;
            led_r       <= LED_NONE;
            pulse_r     <= 1'b0;
`ifdef LED_ANIM_BREATHE_EN
            duty_r      <= {PWM_W{1'b0}};
            duty_dn_r   <= 1'b0;
            pwm_cnt_r   <= {PWM_W{1'b0}};
`endif
        end else begin
            prescaler_r <= prescaler_s;
            mode_r      <= mode_s;
            pos_r       <= pos_s;
            dir_r       <= dir_s;
            fill_r      <= fill_s;
            fill_dn_r   <= fill_dn_s;
            led_r       <= led_s;
            pulse_r     <= pulse_s;
`ifdef LED_ANIM_BREATHE_EN
            duty_r      <= duty_s;
            duty_dn_r   <= duty_dn_s;
            pwm_cnt_r   <= pwm_cnt_s;
`endif
        end
    end

endmodule

// File: tb/tb_led_anim_gen.sv
// Directed self-checking bench for led_anim_gen (N=8 and N=4 instances).
module tb_led_anim_gen;

    logic        clk = 1'b0;
    logic        rst, rst4;
    logic [1:0]  mode, mode4;
    logic [15:0] step_load, step_load4;
    logic [3:0]  brightness, brightness4;
    logic [7:0]  led_out;
    logic [3:0]  led4;
    logic        step_pulse, pulse4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    led_anim_gen #(.N(8), .DIV_W(16), .PWM_W(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .step_load(step_load),
        .brightness(brightness), .led_out(led_out), .step_pulse(step_pulse)
    );

    led_anim_gen #(.N(4), .DIV_W(16), .PWM_W(4)) dut4 (
        .clk(clk), .rst(rst4), .mode(mode4), .step_load(step_load4),
        .brightness(brightness4), .led_out(led4), .step_pulse(pulse4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'd0; step_load = 16'd3; brightness = 4'd0;
        rst4 = 1'b1; mode4 = 2'd2; step_load4 = 16'd0; brightness4 = 4'd0;
        tick();
        tests++; if (led_out !== 8'h00) begin fails++; $display("FAIL reset_led got %h exp 00", led_out); end
        tests++; if (step_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse got %b exp 0", step_pulse); end
        tests++; if (led4 !== 4'h0) begin fails++; $display("FAIL reset_led4 got %h exp 0", led4); end
    endtask

    task automatic test_chase();
        logic [7:0] exp_tab [9] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
        logic [7:0] prev;
        rst = 1'b1; mode = 2'd0; step_load = 16'd3;
        tick();
        rst = 1'b0;
        prev = 8'h00;
        for (int k = 0; k < 9; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                tests++; if (step_pulse !== 1'b0 || led_out !== prev) begin
                    fails++; $display("FAIL chase_idle k=%0d got pulse=%b led=%h exp pulse=0 led=%h", k, step_pulse, led_out, prev);
                end
            end
            tick();
            tests++; if (step_pulse !== 1'b1 || led_out !== exp_tab[k]) begin
                fails++; $display("FAIL chase_step k=%0d got pulse=%b led=%h exp pulse=1 led=%h", k, step_pulse, led_out, exp_tab[k]);
            end
            prev = exp_tab[k];
        end
    endtask

    task automatic test_fill();
        logic [7:0] exp_tab [17] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                                    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h80};
        rst = 1'b1; mode = 2'd1; step_load = 16'd0;
        tick();
        rst = 1'b0;
        tick();
        tests++; if (step_pulse !== 1'b0 || led_out !== 8'h00) begin
            fails++; $display("FAIL fill_modechg got pulse=%b led=%h exp pulse=0 led=00", step_pulse, led_out);
        end
        for (int k = 0; k < 17; k++) begin
            tick();
            tests++; if (step_pulse !== 1'b1 || led_out !== exp_tab[k]) begin
                fails++; $display("FAIL fill_step k=%0d got pulse=%b led=%h exp pulse=1 led=%h", k, step_pulse, led_out, exp_tab[k]);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_tab [8] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4};
        rst4 = 1'b1; mode4 = 2'd2; step_load4 = 16'd0;
        tick();
        rst4 = 1'b0;
        tick();
        tests++; if (led4 !== 4'h0 || pulse4 !== 1'b0) begin
            fails++; $display("FAIL bounce_modechg got pulse=%b led=%h exp pulse=0 led=0", pulse4, led4);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            tests++; if (pulse4 !== 1'b1 || led4 !== exp_tab[k]) begin
                fails++; $display("FAIL bounce_step k=%0d got pulse=%b led=%h exp pulse=1 led=%h", k, pulse4, led4, exp_tab[k]);
            end
        end
    endtask

    task automatic test_mode_switch();
        rst = 1'b1; mode = 2'd0; step_load = 16'd0;
        tick();
        rst = 1'b0;
        tick();
        tests++; if (led_out !== 8'h80) begin fails++; $display("FAIL switch_chase0 got %h exp 80", led_out); end
        tick();
        tests++; if (led_out !== 8'h40) begin fails++; $display("FAIL switch_chase1 got %h exp 40", led_out); end
        mode = 2'd2;
        tick();
        tests++; if (led_out !== 8'h00 || step_pulse !== 1'b0) begin
            fails++; $display("FAIL switch_clear got pulse=%b led=%h exp pulse=0 led=00", step_pulse, led_out);
        end
        tick();
        tests++; if (led_out !== 8'h80 || step_pulse !== 1'b1) begin
            fails++; $display("FAIL switch_first got pulse=%b led=%h exp pulse=1 led=80", step_pulse, led_out);
        end
        tick();
        tests++; if (led_out !== 8'h40) begin fails++; $display("FAIL switch_second got %h exp 40", led_out); end
    endtask

    task automatic test_step_load();
        int pc;
        rst = 1'b1; mode = 2'd0; step_load = 16'd100;
        tick();
        rst = 1'b0;
        pc = 0;
        repeat (50) begin
            tick();
            if (step_pulse) pc++;
        end
        tests++; if (pc !== 0) begin fails++; $display("FAIL sl_prewait got %0d pulses exp 0", pc); end
        step_load = 16'd5;
        tick();
        tests++; if (step_pulse !== 1'b1 || led_out !== 8'h80) begin
            fails++; $display("FAIL sl_shrink got pulse=%b led=%h exp pulse=1 led=80", step_pulse, led_out);
        end
        pc = 0;
        repeat (5) begin
            tick();
            if (step_pulse) pc++;
        end
        tests++; if (pc !== 0) begin fails++; $display("FAIL sl_gap got %0d pulses exp 0", pc); end
        tick();
        tests++; if (step_pulse !== 1'b1 || led_out !== 8'h40) begin
            fails++; $display("FAIL sl_period got pulse=%b led=%h exp pulse=1 led=40", step_pulse, led_out);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        tests++; if (step_pulse !== 1'b0 || led_out !== 8'h00) begin
            fails++; $display("FAIL midrst_clear got pulse=%b led=%h exp pulse=0 led=00", step_pulse, led_out);
        end
        rst = 1'b0; step_load = 16'd0;
        tick();
        tests++; if (step_pulse !== 1'b1 || led_out !== 8'h80) begin
            fails++; $display("FAIL midrst_restart got pulse=%b led=%h exp pulse=1 led=80", step_pulse, led_out);
        end
    endtask

    task automatic run_breathe(input logic [3:0] bright, input int nwin, input int exp_hi [5], input string tag);
        int hi, pc, bad;
        rst = 1'b1; mode = 2'd3; step_load = 16'd15; brightness = bright;
        tick();
        rst = 1'b0;
        tick();
        tests++; if (led_out !== 8'h00 || step_pulse !== 1'b0) begin
            fails++; $display("FAIL %s_modechg got pulse=%b led=%h exp pulse=0 led=00", tag, step_pulse, led_out);
        end
        for (int w = 0; w < nwin; w++) begin
            hi = 0; pc = 0; bad = 0;
            repeat (16) begin
                tick();
                if (led_out === 8'hFF) hi++;
                else if (led_out !== 8'h00) bad++;
                if (step_pulse) pc++;
            end
            tests++; if (hi !== exp_hi[w] || bad !== 0) begin
                fails++; $display("FAIL %s_duty w=%0d got hi=%0d mixed=%0d exp hi=%0d mixed=0", tag, w, hi, bad, exp_hi[w]);
            end
            tests++; if (pc !== 1) begin
                fails++; $display("FAIL %s_pulse w=%0d got %0d pulses exp 1", tag, w, pc);
            end
        end
    endtask

    task automatic test_breathe();
`ifdef LED_ANIM_BREATHE_EN
        int ramp [5] = '{0, 1, 2, 1, 0};
`else
        int ramp [5] = '{0, 0, 0, 0, 0};
`endif
        int dark [5] = '{0, 0, 0, 0, 0};
        run_breathe(4'd2, 5, ramp, "breathe");
        run_breathe(4'd0, 3, dark, "breathe_zero");
    endtask

    initial begin
        test_reset();
        test_chase();
        test_fill();
        test_bounce();
        test_mode_switch();
        test_step_load();
        test_reset_mid();
        test_breathe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
